pipelined_mul_nxn: RTL and testbench

- Parametrised, fully pipelined shift-and-add multiplier. Successor to the fixed 4x4 pipelined multiplier.
- Computes one WIDTH x WIDTH product per clock, with a per-transaction signed/unsigned mode.
- Uses a valid/ready handshake on both sides, with whole-pipeline stall on output backpressure.
- Sits between a producer datapath and a result consumer. Each stage adds one partial product.

---
 rtl/pipelined_mul_nxn.sv | 93 +++++++++
 tb/tb_pipelined_mul_nxn.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_mul_nxn.sv
// Fully pipelined WIDTH x WIDTH shift-and-add multiplier with a per-transaction signed/unsigned mode.
// Each stage adds one partial product; the last stage subtracts it for signed operands.
module pipelined_mul_nxn #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 out_signed
);

  localparam int PW = 2 * WIDTH;

  // Handshake: a beat transfers on a rising edge where valid && ready are both 1.
  // Producer holds data while valid && !ready. The whole pipeline advances only
  // when the output stage is empty or being drained, so in_ready depends on out_ready.
  logic adv;

  logic [WIDTH-1:0] valid_q;
  logic [WIDTH-1:0] mode_q;
  logic [PW-1:0]    sum_q    [WIDTH];
  logic [PW-1:0]    sum_d    [WIDTH];

  // The final stage only carries the finished product, so multiplicand and
  // remaining multiplier bits exist for stages 0..WIDTH-2.
  logic [PW-1:0]    mcand_q  [WIDTH-1];
  logic [WIDTH-1:0] mplier_q [WIDTH-1];

  logic [PW-1:0]    a_ext;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[WIDTH-1];
  assign out_signed = mode_q[WIDTH-1];
  assign p         = sum_q[WIDTH-1];

  assign a_ext = in_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};

  always_comb begin
    logic [PW-1:0] term;
    term = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum_d[k] = '0;
    end
    sum_d[0] = b[0] ? a_ext : '0;
    for (int k = 1; k < WIDTH; k++) begin
      term = mplier_q[k-1][0] ? (mcand_q[k-1] << 1) : '0;
      // The MSB of a two's complement multiplier carries negative weight.
      if ((k == WIDTH - 1) && mode_q[k-1]) begin
        sum_d[k] = sum_q[k-1] - term;
      end else begin
        sum_d[k] = sum_q[k-1] + term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      mode_q  <= '0;
      for (int k = 0; k < WIDTH; k++) begin
        sum_q[k] <= '0;
      end
      for (int k = 0; k < WIDTH - 1; k++) begin
        mcand_q[k]  <= '0;
        mplier_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q[0]  <= in_valid;
      mode_q[0]   <= in_signed;
      sum_q[0]    <= sum_d[0];
      mcand_q[0]  <= a_ext;
      mplier_q[0] <= b >> 1;
      for (int k = 1; k < WIDTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        mode_q[k]  <= mode_q[k-1];
        sum_q[k]   <= sum_d[k];
      end
      for (int k = 1; k < WIDTH - 1; k++) begin
        mcand_q[k]  <= mcand_q[k-1] << 1;
        mplier_q[k] <= mplier_q[k-1] >> 1;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_mul_nxn.sv
// Bench for pipelined_mul_nxn (WIDTH=8): directed corner cases, streaming, backpressure,
// bubbles and mid-stream reset, scored against an arithmetic product model.
module tb_pipelined_mul_nxn;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;
  logic          out_signed;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [PW:0]   exp_q[$];
  logic          hist_ov [4096];
  logic          stalled_prev = 1'b0;
  logic [PW-1:0] prev_p;
  logic          prev_os;
  logic          last_accept;
  logic          last_in_ready;

  always #5 clk = ~clk;

  pipelined_mul_nxn #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_signed  (in_signed),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .p          (p),
    .out_signed (out_signed)
  );

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint xa;
    longint ya;
    longint prod;
    logic [63:0] bits;
    if (s) begin
      xa = longint'($signed(x));
      ya = longint'($signed(y));
    end else begin
      xa = longint'(x);
      ya = longint'(y);
    end
    prod = xa * ya;
    bits = prod;
    return bits[PW-1:0];
  endfunction

  task automatic check(input string tag, input logic [PW:0] obs, input logic [PW:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ov(input string tag, input int idx, input logic e);
    check(tag, {{PW{1'b0}}, hist_ov[idx]}, {{PW{1'b0}}, e});
  endtask

  // One clock cycle: drive at negedge, sample 1ns later, score, record history.
  task automatic step(input logic iv, input logic is, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic ordy);
    logic [PW:0] e;
    @(negedge clk);
    in_valid  = iv;
    in_signed = is;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    if (stalled_prev) begin
      check("stall_hold", {out_signed, p}, {prev_os, prev_p});
      check("stall_valid", {{PW{1'b0}}, out_valid}, {{PW{1'b0}}, 1'b1});
    end
    check("in_ready_rule", {{PW{1'b0}}, in_ready}, {{PW{1'b0}}, (!out_valid || ordy)});
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", {{PW{1'b0}}, out_valid}, '0);
      end else begin
        e = exp_q.pop_front();
        check("product", {out_signed, p}, e);
      end
    end
    last_in_ready = in_ready;
    last_accept   = iv && in_ready;
    if (last_accept) exp_q.push_back({is, ref_mul(av, bv, is)});
    if (cyc < 4096) hist_ov[cyc] = out_valid;
    cyc++;
    stalled_prev = out_valid && !ordy;
    prev_p  = p;
    prev_os = out_signed;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", {{PW{1'b0}}, out_valid}, '0);
    check("rst_p", {1'b0, p}, '0);
    check("rst_out_signed", {{PW{1'b0}}, out_signed}, '0);
    check("rst_in_ready", {{PW{1'b0}}, in_ready}, {{PW{1'b0}}, 1'b1});
    exp_q.delete();
    stalled_prev = 1'b0;
  endtask

  task automatic drain();
    repeat (W + 4) step(1'b0, 1'b0, '0, '0, 1'b1);
    check("drain_empty", (PW+1)'(exp_q.size()), '0);
  endtask

  initial begin
    int c;
    int accepted;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();

    // Single unsigned transaction with latency check.
    c = cyc;
    step(1'b1, 1'b0, 8'd13, 8'd11, 1'b1);
    drain();
    check_ov("lat_before", c + W - 1, 1'b0);
    check_ov("lat_at", c + W, 1'b1);
    check_ov("lat_after", c + W + 1, 1'b0);

    // Back-to-back corner values, mixed modes.
    c = cyc;
    step(1'b1, 1'b1, 8'h80, 8'h80, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 8'h05, 1'b1);
    step(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
    step(1'b1, 1'b1, 8'h7F, 8'h80, 1'b1);
    step(1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
    drain();
    for (int i = 0; i < 5; i++) check_ov("corner_consec", c + W + i, 1'b1);

    // Streaming 20 random mixed-mode pairs.
    c = cyc;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
      check("stream_in_ready", {{PW{1'b0}}, last_in_ready}, {{PW{1'b0}}, 1'b1});
    end
    drain();
    for (int i = 0; i < 20; i++) check_ov("stream_consec", c + W + i, 1'b1);

    // Fill pipeline, then hold out_ready low for 5 cycles.
    for (int i = 0; i < W; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'b0);
      check("bp_in_ready", {{PW{1'b0}}, last_in_ready}, '0);
    end
    drain();

    // Bubble pattern 1,0,0,1.
    c = cyc;
    step(1'b1, 1'b0, 8'd3, 8'd7, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b1, 8'hF0, 8'h0F, 1'b1);
    drain();
    check_ov("bubble_0", c + W, 1'b1);
    check_ov("bubble_1", c + W + 1, 1'b0);
    check_ov("bubble_2", c + W + 2, 1'b0);
    check_ov("bubble_3", c + W + 3, 1'b1);

    // Random out_ready pattern over 100 transactions.
    accepted = 0;
    guard = 0;
    while (accepted < 100 && guard < 3000) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 9) < 6));
      if (last_accept) accepted++;
      guard++;
    end
    check("random_accepted", (PW+1)'(accepted), (PW+1)'(100));
    drain();

    // Reset with 5 transactions in flight: nothing stale may emerge.
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);
    do_reset();
    drain();
    c = cyc;
    step(1'b1, 1'b1, 8'h80, 8'h7F, 1'b1);
    check("post_rst_accept", {{PW{1'b0}}, last_accept}, {{PW{1'b0}}, 1'b1});
    drain();
    check_ov("post_rst_lat_before", c + W - 1, 1'b0);
    check_ov("post_rst_lat_at", c + W, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
